// File: rtl/alu_pkg.sv
// Shared ALU definitions: width defaults, opcode encoding, divider FSM states.
package alu_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned RS_WIDTH_DEF = 2;
  localparam int unsigned OP_WIDTH_DEF = 5;

  localparam int unsigned ALU_ADD    = 0;
  localparam int unsigned ALU_SUB    = 1;
  localparam int unsigned ALU_AND    = 2;
  localparam int unsigned ALU_OR     = 3;
  localparam int unsigned ALU_XOR    = 4;
  localparam int unsigned ALU_SLL    = 5;
  localparam int unsigned ALU_SRL    = 6;
  localparam int unsigned ALU_SRA    = 7;
  localparam int unsigned ALU_SLT    = 8;
  localparam int unsigned ALU_SLTU   = 9;
  localparam int unsigned ALU_BEQ    = 10;
  localparam int unsigned ALU_BGE    = 11;
  localparam int unsigned ALU_BGEU   = 12;
  localparam int unsigned ALU_BNE    = 13;
  localparam int unsigned ALU_MUL    = 16;
  localparam int unsigned ALU_MULH   = 17;
  localparam int unsigned ALU_MULHSU = 18;
  localparam int unsigned ALU_MULHU  = 19;
  localparam int unsigned ALU_DIV    = 20;
  localparam int unsigned ALU_DIVU   = 21;
  localparam int unsigned ALU_REM    = 22;
  localparam int unsigned ALU_REMU   = 23;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue-side and writeback-side handshake bundle of the execution unit.
interface alu_exec_unit_if
  import alu_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned RS_WIDTH = RS_WIDTH_DEF,
  parameter int unsigned OP_WIDTH = OP_WIDTH_DEF
);
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     a;
  logic [XLEN-1:0]     b;
  logic [OP_WIDTH-1:0] alu_op;
  logic [RS_WIDTH-1:0] in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [RS_WIDTH-1:0] out_tag;
  logic [XLEN-1:0]     out_result;

  // RS issue / writeback arbiter side
  modport master (
    output in_valid, a, b, alu_op, in_tag, out_ready,
    input  in_ready, out_valid, out_tag, out_result
  );

  // Execution unit side
  modport slave (
    input  in_valid, a, b, alu_op, in_tag, out_ready,
    output in_ready, out_valid, out_tag, out_result
  );
endinterface

// File: rtl/alu_divider.sv
// Restoring divider, one quotient bit per cycle. Present only when RV32M_EN is defined.
`ifdef RV32M_EN
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic            ack_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, sel_rem_q, sel_rem_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, quo_res, rem_res;
  logic [XLEN:0]   r_shift, diff;

  assign a_neg   = signed_i & a_i[XLEN-1];
  assign b_neg   = signed_i & b_i[XLEN-1];
  assign a_mag   = a_neg ? -a_i : a_i;
  assign b_mag   = b_neg ? -b_i : b_i;
  assign r_shift = {rem_q, quo_q[XLEN-1]};
  assign diff    = r_shift - {1'b0, dvs_q};

  // State register; frozen when the unit is globally disabled, reset always wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      sel_rem_q <= 1'b0;
    end else if (en_i) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      sel_rem_q <= sel_rem_d;
    end
  end

  // Next state: special cases jump straight to DONE, others iterate XLEN steps
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    sel_rem_d = sel_rem_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          sel_rem_d = rem_i;
          qneg_d    = 1'b0;
          rneg_d    = 1'b0;
          if (b_i == '0) begin
            quo_d   = '1;
            rem_d   = a_i;
            state_d = DIV_DONE;
          end else if (signed_i && (a_i == MIN_VAL) && (b_i == '1)) begin
            quo_d   = MIN_VAL;
            rem_d   = '0;
            state_d = DIV_DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = CW'(XLEN);
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        if (diff[XLEN]) begin
          rem_d = r_shift[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (ack_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (abort_i) state_d = DIV_IDLE;
  end

  assign quo_res  = qneg_q ? -quo_q : quo_q;
  assign rem_res  = rneg_q ? -rem_q : rem_q;
  assign result_o = sel_rem_q ? rem_res : quo_res;
  assign busy_o   = (state_q != DIV_IDLE);
  assign done_o   = (state_q == DIV_DONE);

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// Pipelined ALU execution unit with valid/ready on both sides and a held result register.
// Optional RV32M multiply/divide enabled by defining RV32M_EN.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned RS_WIDTH = RS_WIDTH_DEF,
  parameter int unsigned OP_WIDTH = OP_WIDTH_DEF
) (
  input logic            clk_in,
  input logic            rst_in,
  input logic            rdy_in,
  input logic            clear,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  logic                in_ready, accept, single_acc, is_div, div_busy;
  logic [XLEN-1:0]     alu_res;
  logic [SHW-1:0]      shamt;
  logic                out_valid_q, out_valid_d;
  logic [RS_WIDTH-1:0] out_tag_q, out_tag_d;
  logic [XLEN-1:0]     out_result_q, out_result_d;

  // out_ready -> in_ready is a deliberate combinational path
  assign in_ready   = rdy_in & ~clear & ~div_busy & (~out_valid_q | bus.out_ready);
  assign accept     = bus.in_valid & in_ready;
  assign single_acc = accept & ~is_div;
  assign shamt      = bus.b[SHW-1:0];

`ifdef RV32M_EN
  logic                div_start, div_done, div_ack, div_signed, div_rem;
  logic [XLEN-1:0]     div_result, mul_lo, mulh_ss, mulh_su, mulh_uu;
  logic [2*XLEN-1:0]   a_sx, a_zx, b_sx, b_zx;
  logic [RS_WIDTH-1:0] div_tag_q, div_tag_d;

  assign a_sx    = {{XLEN{bus.a[XLEN-1]}}, bus.a};
  assign a_zx    = {{XLEN{1'b0}}, bus.a};
  assign b_sx    = {{XLEN{bus.b[XLEN-1]}}, bus.b};
  assign b_zx    = {{XLEN{1'b0}}, bus.b};
  assign mul_lo  = bus.a * bus.b;
  assign mulh_ss = XLEN'((a_sx * b_sx) >> XLEN);
  assign mulh_su = XLEN'((a_sx * b_zx) >> XLEN);
  assign mulh_uu = XLEN'((a_zx * b_zx) >> XLEN);

  assign div_start = accept & is_div;
  assign div_ack   = rdy_in & ~clear & div_done & (~out_valid_q | bus.out_ready);

  alu_divider #(.XLEN(XLEN)) u_div (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .en_i     (rdy_in),
    .start_i  (div_start),
    .abort_i  (clear),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .signed_i (div_signed),
    .rem_i    (div_rem),
    .ack_i    (div_ack),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .result_o (div_result)
  );

  // Tag of the divide in flight, captured at accept
  always_ff @(posedge clk_in) begin
    if (rst_in) div_tag_q <= '0;
    else        div_tag_q <= div_tag_d;
  end

  always_comb begin
    div_tag_d = div_tag_q;
    if (div_start) div_tag_d = bus.in_tag;
  end
`else
  assign div_busy = 1'b0;
`endif

  // Single-cycle result decode; undefined opcodes yield zero
  always_comb begin
    alu_res = '0;
    is_div  = 1'b0;
`ifdef RV32M_EN
    div_signed = 1'b0;
    div_rem    = 1'b0;
`endif
    case (bus.alu_op)
      OP_WIDTH'(ALU_ADD):  alu_res = bus.a + bus.b;
      OP_WIDTH'(ALU_SUB):  alu_res = bus.a - bus.b;
      OP_WIDTH'(ALU_AND):  alu_res = bus.a & bus.b;
      OP_WIDTH'(ALU_OR):   alu_res = bus.a | bus.b;
      OP_WIDTH'(ALU_XOR):  alu_res = bus.a ^ bus.b;
      OP_WIDTH'(ALU_SLL):  alu_res = bus.a << shamt;
      OP_WIDTH'(ALU_SRL):  alu_res = bus.a >> shamt;
      OP_WIDTH'(ALU_SRA):  alu_res = XLEN'($signed(bus.a) >>> shamt);
      OP_WIDTH'(ALU_SLT):  alu_res = XLEN'($signed(bus.a) < $signed(bus.b));
      OP_WIDTH'(ALU_SLTU): alu_res = XLEN'(bus.a < bus.b);
      OP_WIDTH'(ALU_BEQ):  alu_res = XLEN'(bus.a == bus.b);
      OP_WIDTH'(ALU_BGE):  alu_res = XLEN'($signed(bus.a) >= $signed(bus.b));
      OP_WIDTH'(ALU_BGEU): alu_res = XLEN'(bus.a >= bus.b);
      OP_WIDTH'(ALU_BNE):  alu_res = XLEN'(bus.a != bus.b);
`ifdef RV32M_EN
      OP_WIDTH'(ALU_MUL):    alu_res = mul_lo;
      OP_WIDTH'(ALU_MULH):   alu_res = mulh_ss;
      OP_WIDTH'(ALU_MULHSU): alu_res = mulh_su;
      OP_WIDTH'(ALU_MULHU):  alu_res = mulh_uu;
      OP_WIDTH'(ALU_DIV):  begin is_div = 1'b1; div_signed = 1'b1; end
      OP_WIDTH'(ALU_DIVU): begin is_div = 1'b1; end
      OP_WIDTH'(ALU_REM):  begin is_div = 1'b1; div_signed = 1'b1; div_rem = 1'b1; end
      OP_WIDTH'(ALU_REMU): begin is_div = 1'b1; div_rem = 1'b1; end
`endif
      default: alu_res = '0;
    endcase
  end

  // Output holding register state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid_q  <= 1'b0;
      out_tag_q    <= '0;
      out_result_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_tag_q    <= out_tag_d;
      out_result_q <= out_result_d;
    end
  end

  // Output register next state: flush, load, drain; everything holds while rdy_in is low
  always_comb begin
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    out_result_d = out_result_q;
    if (rdy_in) begin
      if (clear) begin
        out_valid_d = 1'b0;
      end else if (single_acc) begin
        out_valid_d  = 1'b1;
        out_tag_d    = bus.in_tag;
        out_result_d = alu_res;
`ifdef RV32M_EN
      end else if (div_ack) begin
        out_valid_d  = 1'b1;
        out_tag_d    = div_tag_q;
        out_result_d = div_result;
`endif
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_result = out_result_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (RV32M sections follow the RV32M_EN macro).
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RSW  = 2;
  localparam int unsigned OPW  = 5;

  logic clk = 1'b0;
  logic rst_in, rdy_in, clear;
  int   tests = 0;
  int   fails = 0;

  alu_exec_unit_if #(.XLEN(XLEN), .RS_WIDTH(RSW), .OP_WIDTH(OPW)) bus ();

  alu_exec_unit #(.XLEN(XLEN), .RS_WIDTH(RSW), .OP_WIDTH(OPW)) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] tag);
    bus.in_valid = 1'b1;
    bus.alu_op   = 5'(op);
    bus.a        = a;
    bus.b        = b;
    bus.in_tag   = tag;
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.alu_op = '0; bus.in_tag = '0;
    tick(); tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.out_tag !== 2'd0) begin fails++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
    tests++; if (bus.out_result !== 32'h0) begin fails++; $display("FAIL reset_out_result: got %h want 0", bus.out_result); end
    rst_in = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_alu_ops();
    int          ops [17] = '{ALU_ADD, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_AND, ALU_OR,
                              ALU_XOR, ALU_BEQ, ALU_BGE, ALU_BGEU, ALU_BNE, 14, 31, ALU_SUB, ALU_MUL};
    logic [31:0] va  [17] = '{32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h80000000,
                              32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,
                              32'd5, 32'd5, 32'd3, 32'd3};
    logic [31:0] vb  [17] = '{32'd7, 32'h21, 32'd1, 32'd1, 32'd4, 32'h1F, 32'hFF00, 32'hFF00, 32'hFF00,
                              32'd5, 32'd1, 32'd1, 32'd5, 32'd7, 32'd7, 32'd5, 32'd4};
`ifdef RV32M_EN
    logic [31:0] mul_exp = 32'd12;
`else
    logic [31:0] mul_exp = 32'd0;
`endif
    logic [31:0] vexp [17] = '{32'd12, 32'hC0000000, 32'd1, 32'd0, 32'h10, 32'd1, 32'hF000, 32'hFFF0,
                               32'h0FF0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFE, 32'd0};
    vexp[16] = mul_exp;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_op(ops[i], va[i], vb[i], 2'(i));
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL op%0d_in_ready: got %b want 1", i, bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== vexp[i] || bus.out_tag !== 2'(i)) begin
        fails++;
        $display("FAIL op%0d (opcode %0d): got v=%b r=%h t=%0d want v=1 r=%h t=%0d",
                 i, ops[i], bus.out_valid, bus.out_result, bus.out_tag, vexp[i], i % 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_op(ALU_ADD, 32'(i), 32'(i * 10), 2'(i));
      tick();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'(i * 11) || bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_%0d: got v=%b r=%h rdy=%b want v=1 r=%h rdy=1",
                 i, bus.out_valid, bus.out_result, bus.in_ready, i * 11);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    set_op(ALU_SUB, 32'd9, 32'd3, 2'd1);
    tick();
    set_op(ALU_XOR, 32'hF0, 32'h0F, 2'd3);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_low: got %b want 0", bus.in_ready); end
    tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd6 || bus.out_tag !== 2'd1) begin
      fails++;
      $display("FAIL bp_hold: got v=%b r=%h t=%0d want v=1 r=6 t=1", bus.out_valid, bus.out_result, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready_high: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFF || bus.out_tag !== 2'd3) begin
      fails++;
      $display("FAIL bp_replace: got v=%b r=%h t=%0d want v=1 r=ff t=3", bus.out_valid, bus.out_result, bus.out_tag);
    end
    tick();
  endtask

  task automatic test_clear();
    bus.out_ready = 1'b0;
    set_op(ALU_ADD, 32'd1, 32'd2, 2'd1);
    tick();
    rdy_in = 1'b0; clear = 1'b1; bus.out_ready = 1'b1;
    set_op(ALU_ADD, 32'd10, 32'd10, 2'd2);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL frozen_in_ready: got %b want 0", bus.in_ready); end
    tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd3 || bus.out_tag !== 2'd1) begin
      fails++;
      $display("FAIL frozen_hold: got v=%b r=%h t=%0d want v=1 r=3 t=1", bus.out_valid, bus.out_result, bus.out_tag);
    end
    rdy_in = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL clear_in_ready: got %b want 0", bus.in_ready); end
    tick();
    clear = 1'b0; bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL clear_out_valid: got %b want 0", bus.out_valid); end
  endtask

`ifdef RV32M_EN
  task automatic test_mul();
    int          ops [3] = '{ALU_MULH, ALU_MULHU, ALU_MULHSU};
    logic [31:0] va  [3] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] vexp[3] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(ops[i], va[i], 32'd2, 2'd2);
      tick();
      bus.in_valid = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== vexp[i]) begin
        fails++;
        $display("FAIL mul%0d: got v=%b r=%h want v=1 r=%h", i, bus.out_valid, bus.out_result, vexp[i]);
      end
    end
  endtask

  task automatic test_div();
    int          ops [9] = '{ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REM, ALU_DIV};
    logic [31:0] va  [9] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h1234, 32'h1234, 32'h80000000, 32'h80000000,
                             32'd100, 32'd7, 32'd7};
    logic [31:0] vb  [9] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7,
                             32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] vexp[9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'd0,
                             32'd14, 32'd1, 32'hFFFFFFFD};
    int          vlat[9] = '{33, 33, 1, 1, 1, 1, 33, 33, 33};
    int          n;
    logic        bad_rdy;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_op(ops[i], va[i], vb[i], 2'(i));
      tick();
      bus.in_valid = 1'b0;
      n = 0; bad_rdy = 1'b0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
        if (bus.in_ready !== 1'b0) bad_rdy = 1'b1;
        tick();
        n++;
      end
      tests++;
      if (n != vlat[i] || bus.out_result !== vexp[i] || bus.out_tag !== 2'(i) || bad_rdy) begin
        fails++;
        $display("FAIL div%0d (opcode %0d): got lat=%0d r=%h t=%0d rdy_leak=%b want lat=%0d r=%h t=%0d rdy_leak=0",
                 i, ops[i], n, bus.out_result, bus.out_tag, bad_rdy, vlat[i], vexp[i], i % 4);
      end
    end
    tick();
  endtask

  task automatic test_div_abort();
    int   n;
    logic late;
    bus.out_ready = 1'b1;
    // frozen for 3 cycles with clear asserted: divide survives, finishes 3 edges late
    set_op(ALU_DIVU, 32'd100, 32'd7, 2'd2);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rdy_in = 1'b0; clear = 1'b1;
    repeat (3) tick();
    rdy_in = 1'b1; clear = 1'b0;
    n = 8;
    while (bus.out_valid !== 1'b1 && n < 100) begin tick(); n++; end
    tests++;
    if (n != 36 || bus.out_result !== 32'd14) begin
      fails++; $display("FAIL div_frozen: got lat=%0d r=%h want lat=36 r=e", n, bus.out_result);
    end
    tick();
    // clear mid-divide aborts with no late result
    set_op(ALU_DIVU, 32'd100, 32'd7, 2'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL div_clear: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    late = 1'b0;
    repeat (40) begin tick(); if (bus.out_valid !== 1'b0) late = 1'b1; end
    tests++; if (late) begin fails++; $display("FAIL div_clear_late: got late result want none"); end
    // reset mid-divide acts even while rdy_in is low
    set_op(ALU_DIVU, 32'd100, 32'd7, 2'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rdy_in = 1'b0; rst_in = 1'b1;
    tick();
    rst_in = 1'b0; rdy_in = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL div_reset: got rdy=%b want 1", bus.in_ready); end
    late = 1'b0;
    repeat (40) begin tick(); if (bus.out_valid !== 1'b0) late = 1'b1; end
    tests++; if (late) begin fails++; $display("FAIL div_reset_late: got late result want none"); end
  endtask
`else
  task automatic test_rv32m_disabled();
    int ops[3] = '{ALU_DIV, ALU_MULH, ALU_REMU};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(ops[i], 32'd100, 32'd7, 2'd1);
      tick();
      bus.in_valid = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0 || bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL nom_op%0d: got v=%b r=%h rdy=%b want v=1 r=0 rdy=1",
                 ops[i], bus.out_valid, bus.out_result, bus.in_ready);
      end
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_ops();
    test_back_to_back();
    test_backpressure();
    test_clear();
`ifdef RV32M_EN
    test_mul();
    test_div();
    test_div_abort();
`else
    test_rv32m_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
